// File: rtl/sync_fifo.sv
// Single-clock FIFO: circular memory with wrap-compare pointers and an occupancy
// counter, so any DEPTH >= 2 works. RD_BUFFER selects registered or fall-through read data.
module sync_fifo #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RD_BUFFER  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  wr_en,
  output logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  rd_en,
  output logic                  fifo_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_accept;
  logic                  rd_accept;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign wr_accept  = wr_en & ~fifo_full;
  assign rd_accept  = rd_en & ~fifo_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if (RD_BUFFER != 0) begin : g_rd_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_rd <= '0;
      end else if (rd_accept) begin
        data_rd <= mem[rd_ptr];
      end
    end
  end else begin : g_rd_fwft
    assign data_rd = mem[rd_ptr];
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a registered-read and a fall-through instance with identical random
// traffic and checks both against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 12;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_wr = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;

  logic          full_reg, empty_reg, full_ff, empty_ff;
  logic [DW-1:0] rd_reg, rd_ff;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_BUFFER(1)) dut_reg (
    .clk(clk), .rst(rst), .data_wr(data_wr), .wr_en(wr_en),
    .fifo_full(full_reg), .data_rd(rd_reg), .rd_en(rd_en), .fifo_empty(empty_reg)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_BUFFER(0)) dut_ff (
    .clk(clk), .rst(rst), .data_wr(data_wr), .wr_en(wr_en),
    .fifo_full(full_ff), .data_rd(rd_ff), .rd_en(rd_en), .fifo_empty(empty_ff)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    logic exp_full, exp_empty;
    exp_full  = (model_q.size() == DEPTH);
    exp_empty = (model_q.size() == 0);
    check({tag, ".full_reg"},  32'(full_reg),  32'(exp_full));
    check({tag, ".empty_reg"}, 32'(empty_reg), 32'(exp_empty));
    check({tag, ".full_ff"},   32'(full_ff),   32'(exp_full));
    check({tag, ".empty_ff"},  32'(empty_ff),  32'(exp_empty));
  endtask

  // One clock of traffic: inputs applied now, head checked before the edge,
  // model updated from the pre-edge occupancy, outputs checked after the edge.
  task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    bit wa, ra;
    wr_en   = w;
    rd_en   = r;
    data_wr = d;
    @(negedge clk);
    if (model_q.size() != 0) check({tag, ".head_ff"}, 32'(rd_ff), 32'(model_q[0]));
    wa = w && (model_q.size() < DEPTH);
    ra = r && (model_q.size() > 0);
    if (ra) last_rd = model_q.pop_front();
    if (wa) model_q.push_back(d);
    @(posedge clk);
    #1;
    check_flags(tag);
    check({tag, ".data_reg"}, 32'(rd_reg), 32'(last_rd));
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1;
    check("reset.empty_reg", 32'(empty_reg), 32'd1);
    check("reset.full_reg",  32'(full_reg),  32'd0);
    check("reset.data_reg",  32'(rd_reg),    32'd0);
    check("reset.empty_ff",  32'(empty_ff),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) step("fill", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 15; i++) step("drain", 1'b0, 1'b1, DW'($urandom));

    for (int ops = 0; ops < 240; ) begin
      int unsigned len = $urandom_range(1, 12);
      bit is_wr = $urandom_range(0, 1) == 1;
      for (int k = 0; k < int'(len); k++) begin
        step(is_wr ? "burst_wr" : "burst_rd", is_wr, !is_wr, DW'($urandom));
        ops++;
      end
    end
    while (model_q.size() != 0) step("flush", 1'b0, 1'b1, '0);

    for (int i = 0; i < 12; i++) step("stream", 1'b1, 1'b1, DW'($urandom));
    step("stream_tail", 1'b0, 1'b1, '0);

    while (model_q.size() < DEPTH) step("refill", 1'b1, 1'b0, DW'($urandom));
    step("full_rw", 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 13; i++) step("after_rw", 1'b0, 1'b1, '0);

    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, DW'($urandom));
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    last_rd = '0;
    check("midrst.empty_reg", 32'(empty_reg), 32'd1);
    check("midrst.full_reg",  32'(full_reg),  32'd0);
    check("midrst.data_reg",  32'(rd_reg),    32'd0);
    check("midrst.empty_ff",  32'(empty_ff),  32'd1);
    check("midrst.full_ff",   32'(full_ff),   32'd0);
    #1;
    rst = 1'b1;
    step("rd_after_rst", 1'b0, 1'b1, '0);
    step("rd_after_rst2", 1'b0, 1'b1, '0);

    for (int i = 0; i < 40; i++)
      step("mixed", $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, DW'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
